// File: rtl/mux_scan_pkg.sv
// Shared constants and state encoding for the 16:1 mux scan controller.
package mux_scan_pkg;

    localparam int unsigned NUM_CH = 16;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StOut  = 2'd2
    } state_e;

endpackage

// File: rtl/next_ch_find.sv
// Finds the lowest enabled channel strictly above `cur`, or the lowest enabled
// channel overall when `from_below` is set.
module next_ch_find
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    input  logic              from_below,
    output logic [SEL_W-1:0]  nxt,
    output logic              found
);

    always_comb begin
        nxt   = '0;
        found = 1'b0;
        // Walk downward so the last hit is the lowest qualifying channel.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (from_below || (SEL_W'(i) > cur))) begin
                nxt   = SEL_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_seq.sv
// Scan controller: steps a 16:1 mux select through enabled channels, samples
// each after a settle window, and hands the assembled word out via valid/ready.
module mux_scan_seq
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont,
    input  logic [NUM_CH-1:0] mask,
    output logic [SEL_W-1:0]  mux_sel,
    input  logic              mux_y,
    output logic [NUM_CH-1:0] data,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              busy
);

    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic              cont_q, cont_d;
    logic [NUM_CH-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [NUM_CH-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;

    logic [NUM_CH-1:0] find_mask;
    logic [SEL_W-1:0]  find_cur;
    logic              find_low;
    logic [SEL_W-1:0]  find_idx;
    logic              find_found;

    // One search block serves both "next above current" and "lowest enabled".
    next_ch_find u_next_ch_find (
        .mask       (find_mask),
        .cur        (find_cur),
        .from_below (find_low),
        .nxt        (find_idx),
        .found      (find_found)
    );

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        cont_d    = cont_q;
        shadow_d  = shadow_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        data_d    = data_q;
        valid_d   = valid_q;
        find_mask = mask_q;
        find_cur  = sel_q;
        find_low  = 1'b0;

        case (state_q)
            StIdle: begin
                sel_d     = '0;
                find_mask = mask;
                find_low  = 1'b1;
                if (start) begin
                    mask_d   = mask;
                    cont_d   = cont;
                    shadow_d = '0;
                    cnt_d    = '0;
                    if (find_found) begin
                        state_d = StScan;
                        sel_d   = find_idx;
                    end else begin
                        state_d = StOut;
                        data_d  = '0;
                        valid_d = 1'b1;
                    end
                end
            end
            StScan: begin
                if (cnt_q == SETTLE_CNT) begin
                    shadow_d[sel_q] = mux_y;
                    cnt_d           = '0;
                    if (find_found) begin
                        sel_d = find_idx;
                    end else begin
                        state_d = StOut;
                        data_d  = shadow_d;
                        valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StOut: begin
                find_low = 1'b1;
                if (data_ready) begin
                    valid_d = 1'b0;
                    if (cont_q) begin
                        shadow_d = '0;
                        cnt_d    = '0;
                        if (find_found) begin
                            state_d = StScan;
                            sel_d   = find_idx;
                        end else begin
                            // Empty mask in continuous mode: emit another zero word.
                            data_d  = '0;
                            valid_d = 1'b1;
                        end
                    end else begin
                        state_d = StIdle;
                        sel_d   = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                sel_d   = '0;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mask_q   <= '0;
            cont_q   <= 1'b0;
            shadow_q <= '0;
            cnt_q    <= '0;
            sel_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            cont_q   <= cont_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign mux_sel    = sel_q;
    assign data       = data_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed bench: three instances (SETTLE = 0, 1, 2) share stimulus; each test
// checks the instance whose settle count it targets.
module tb_mux_scan_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic [15:0] mask = 16'h0;
    logic        data_ready = 1'b0;
    logic [15:0] in_word = 16'h0;

    logic [3:0]  sel0, sel1, sel2;
    logic [15:0] dat0, dat1, dat2;
    logic        dv0, dv1, dv2;
    logic        busy0, busy1, busy2;
    logic        y0, y1, y2;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign y0 = in_word[sel0];
    assign y1 = in_word[sel1];
    assign y2 = in_word[sel2];

    mux_scan_seq #(.SETTLE(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .mask(mask),
        .mux_sel(sel0), .mux_y(y0), .data(dat0), .data_valid(dv0),
        .data_ready(data_ready), .busy(busy0)
    );
    mux_scan_seq #(.SETTLE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .mask(mask),
        .mux_sel(sel1), .mux_y(y1), .data(dat1), .data_valid(dv1),
        .data_ready(data_ready), .busy(busy1)
    );
    mux_scan_seq #(.SETTLE(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .mask(mask),
        .mux_sel(sel2), .mux_y(y2), .data(dat2), .data_valid(dv2),
        .data_ready(data_ready), .busy(busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        cont  = 1'b0;
        mask  = 16'h0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Returns #1 after the accepting edge E0.
    task automatic accept(input logic [15:0] m, input logic c);
        start = 1'b1;
        mask  = m;
        cont  = c;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (sel1 !== 4'h0) begin n_fail++; $display("FAIL reset_sel got %h want 0", sel1); end
        n_checks++; if (dat1 !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", dat1); end
        n_checks++; if (dv1 !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", dv1); end
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy1); end
        n_checks++; if ({dv0, dv2} !== 2'b00) begin n_fail++; $display("FAIL reset_valid_others got %b want 00", {dv0, dv2}); end
    endtask

    task automatic test_full_mask();
        do_reset();
        in_word = 16'hA5C3;
        data_ready = 1'b1;
        accept(16'hFFFF, 1'b0);
        n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL full_busy got %b want 1", busy1); end
        for (int c = 0; c < 32; c++) begin
            n_checks++;
            if (sel1 !== 4'(c / 2) || dv1 !== 1'b0) begin
                n_fail++;
                $display("FAIL full_step cyc %0d got sel=%h dv=%b want sel=%h dv=0", c, sel1, dv1, 4'(c / 2));
            end
            tick();
        end
        n_checks++; if (dv1 !== 1'b1) begin n_fail++; $display("FAIL full_valid got %b want 1", dv1); end
        n_checks++; if (dat1 !== 16'hA5C3) begin n_fail++; $display("FAIL full_data got %h want a5c3", dat1); end
        tick();
        n_checks++; if (dv1 !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL full_done got dv=%b busy=%b want 0 0", dv1, busy1); end
        n_checks++; if (sel1 !== 4'h0) begin n_fail++; $display("FAIL full_idle_sel got %h want 0", sel1); end
    endtask

    task automatic test_sparse_mask();
        do_reset();
        in_word = 16'hFFFF;
        data_ready = 1'b1;
        accept(16'h8001, 1'b0);
        n_checks++; if (sel0 !== 4'h0 || dv0 !== 1'b0) begin n_fail++; $display("FAIL sparse_ch0 got sel=%h dv=%b want 0 0", sel0, dv0); end
        tick();
        n_checks++; if (sel0 !== 4'hF || dv0 !== 1'b0) begin n_fail++; $display("FAIL sparse_ch15 got sel=%h dv=%b want f 0", sel0, dv0); end
        tick();
        n_checks++; if (dv0 !== 1'b1) begin n_fail++; $display("FAIL sparse_valid got %b want 1", dv0); end
        n_checks++; if (dat0 !== 16'h8001) begin n_fail++; $display("FAIL sparse_data got %h want 8001", dat0); end
    endtask

    task automatic test_empty_mask();
        do_reset();
        data_ready = 1'b0;
        accept(16'h0000, 1'b0);
        n_checks++; if (dv1 !== 1'b1 || dat1 !== 16'h0) begin n_fail++; $display("FAIL empty_word got dv=%b data=%h want 1 0000", dv1, dat1); end
        n_checks++; if (sel1 !== 4'h0 || busy1 !== 1'b1) begin n_fail++; $display("FAIL empty_sel_busy got sel=%h busy=%b want 0 1", sel1, busy1); end
        tick();
        n_checks++; if (dv1 !== 1'b1 || sel1 !== 4'h0) begin n_fail++; $display("FAIL empty_hold got dv=%b sel=%h want 1 0", dv1, sel1); end
        data_ready = 1'b1;
        tick();
        n_checks++; if (dv1 !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL empty_xfer got dv=%b busy=%b want 0 0", dv1, busy1); end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_word = 16'h0010;
        data_ready = 1'b0;
        accept(16'h0011, 1'b0);
        for (int c = 0; c < 4; c++) begin
            n_checks++; if (dv1 !== 1'b0) begin n_fail++; $display("FAIL bp_early_valid cyc %0d got %b want 0", c, dv1); end
            tick();
        end
        n_checks++; if (dv1 !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %b want 1", dv1); end
        for (int k = 0; k < 10; k++) begin
            start = (k % 3 == 0);
            mask  = 16'hFFFF;
            tick();
            n_checks++;
            if (dv1 !== 1'b1 || dat1 !== 16'h0010 || busy1 !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold cyc %0d got dv=%b data=%h busy=%b want 1 0010 1", k, dv1, dat1, busy1);
            end
        end
        start = 1'b0;
        data_ready = 1'b1;
        tick();
        n_checks++; if (dv1 !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL bp_xfer got dv=%b busy=%b want 0 0", dv1, busy1); end
        n_checks++; if (dat1 !== 16'h0010) begin n_fail++; $display("FAIL bp_idle_data got %h want 0010", dat1); end
        data_ready = 1'b0;
        tick();
        n_checks++; if (busy1 !== 1'b0 || sel1 !== 4'h0) begin n_fail++; $display("FAIL bp_start_ignored got busy=%b sel=%h want 0 0", busy1, sel1); end
    endtask

    // Runs straight after test_backpressure so the pre-reset data is nonzero.
    task automatic test_reset_mid_scan();
        in_word = 16'h1234;
        data_ready = 1'b0;
        accept(16'hFFFF, 1'b0);
        for (int c = 0; c < 10; c++) tick();
        n_checks++; if (sel1 !== 4'h5) begin n_fail++; $display("FAIL mid_sel got %h want 5", sel1); end
        rst_n = 1'b0;
        tick();
        n_checks++; if (sel1 !== 4'h0 || dv1 !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ctl got sel=%h dv=%b busy=%b want 0 0 0", sel1, dv1, busy1); end
        n_checks++; if (dat1 !== 16'h0) begin n_fail++; $display("FAIL mid_reset_data got %h want 0", dat1); end
        rst_n = 1'b1;
        data_ready = 1'b1;
        tick();
        accept(16'hFFFF, 1'b0);
        for (int c = 0; c < 32; c++) tick();
        n_checks++; if (dv1 !== 1'b1 || dat1 !== 16'h1234) begin n_fail++; $display("FAIL mid_rescan got dv=%b data=%h want 1 1234", dv1, dat1); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_word = 16'h0001;
        data_ready = 1'b0;
        accept(16'h0003, 1'b1);
        mask = 16'hFFFF;
        cont = 1'b0;
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if (sel2 !== ((c < 3) ? 4'h0 : 4'h1) || dv2 !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_first cyc %0d got sel=%h dv=%b", c, sel2, dv2);
            end
            tick();
        end
        n_checks++; if (dv2 !== 1'b1 || dat2 !== 16'h0001) begin n_fail++; $display("FAIL b2b_word1 got dv=%b data=%h want 1 0001", dv2, dat2); end
        in_word = 16'h0002;
        data_ready = 1'b1;
        tick();
        n_checks++; if (dv2 !== 1'b0 || busy2 !== 1'b1) begin n_fail++; $display("FAIL b2b_restart got dv=%b busy=%b want 0 1", dv2, busy2); end
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if (sel2 !== ((c < 3) ? 4'h0 : 4'h1) || dv2 !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_second cyc %0d got sel=%h dv=%b", c, sel2, dv2);
            end
            tick();
        end
        n_checks++; if (dv2 !== 1'b1 || dat2 !== 16'h0002) begin n_fail++; $display("FAIL b2b_word2 got dv=%b data=%h want 1 0002", dv2, dat2); end
        do_reset();
        n_checks++; if (busy2 !== 1'b0 || dv2 !== 1'b0) begin n_fail++; $display("FAIL b2b_stop got busy=%b dv=%b want 0 0", busy2, dv2); end
    endtask

    initial begin
        test_reset();
        test_full_mask();
        test_sparse_mask();
        test_empty_mask();
        test_backpressure();
        test_reset_mid_scan();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
